// File: rtl/time_set_editor.sv
// Time-of-day editor: captures the live BCD time, lets the user adjust hour/min/sec with
// debounced buttons, then loads the result into the running counter with a one-cycle strobe.
module time_set_editor #(
  parameter int unsigned DB_CYCLES  = 1_000_000,
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] nowtime,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_confirm,
  output logic [23:0] save_nowtime,
  output logic        save_nowtime_yet,
  output logic [1:0]  edit_field,
  output logic        edit_active,
  output logic        blink
);

  localparam int unsigned DbW = $clog2(DB_CYCLES + 1);
  localparam int unsigned BlW = $clog2(BLINK_HALF + 1);

  localparam int unsigned BConfirm = 0;
  localparam int unsigned BUp      = 1;
  localparam int unsigned BDown    = 2;
  localparam int unsigned BLeft    = 3;
  localparam int unsigned BRight   = 4;

  typedef enum logic [1:0] {StIdle, StLoad, StEdit, StCommit} state_e;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
    if (v == maxv)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] maxv);
    if (v == 8'h00)          return maxv;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // A field with a non-decimal ones nibble or out of range is replaced by 00.
  function automatic logic [7:0] sanitize(input logic [7:0] v, input logic [7:0] maxv);
    if (v[3:0] <= 4'd9 && v <= maxv) return v;
    else                             return 8'h00;
  endfunction

  logic [4:0]     raw;
  logic [4:0]     sync1_q, sync2_q, db_q, press_q;
  logic [DbW-1:0] db_cnt_q [5];

  assign raw = {btn_right, btn_left, btn_down, btn_up, btn_confirm};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      press_q <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
          press_q[i]  <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  state_e         state_q;
  logic [23:0]    work_q, save_q;
  logic           strobe_q, active_q, blink_q;
  logic [1:0]     field_q;
  logic [BlW-1:0] blink_cnt_q;

  logic [7:0]  sel_val, sel_max, new_val;
  logic [23:0] work_upd;
  logic        field_chg;

  always_comb begin
    sel_val = work_q[7:0];
    sel_max = 8'h59;
    case (field_q)
      2'd2:    begin sel_val = work_q[23:16]; sel_max = 8'h23; end
      2'd1:    sel_val = work_q[15:8];
      default: sel_val = work_q[7:0];
    endcase
    new_val  = press_q[BUp] ? bcd_inc(sel_val, sel_max) : bcd_dec(sel_val, sel_max);
    work_upd = work_q;
    case (field_q)
      2'd2:    work_upd[23:16] = new_val;
      2'd1:    work_upd[15:8]  = new_val;
      default: work_upd[7:0]   = new_val;
    endcase
    field_chg = !press_q[BUp] && !press_q[BDown] && (press_q[BLeft] || press_q[BRight]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      work_q      <= '0;
      save_q      <= '0;
      strobe_q    <= 1'b0;
      field_q     <= 2'd2;
      active_q    <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      strobe_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q  <= StLoad;
            active_q <= 1'b1;
          end
        end
        StLoad: begin
          work_q      <= {sanitize(nowtime[23:16], 8'h23), sanitize(nowtime[15:8], 8'h59),
                          sanitize(nowtime[7:0], 8'h59)};
          field_q     <= 2'd2;
          blink_q     <= 1'b0;
          blink_cnt_q <= '0;
          state_q     <= StEdit;
        end
        StEdit: begin
          if (!enable || press_q[BConfirm]) begin
            state_q     <= enable ? StCommit : StIdle;
            active_q    <= 1'b0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
          end else begin
            if (press_q[BUp] || press_q[BDown]) begin
              work_q <= work_upd;
            end else if (press_q[BLeft]) begin
              field_q <= (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
            end else if (press_q[BRight]) begin
              field_q <= (field_q == 2'd0) ? 2'd2 : field_q - 2'd1;
            end
            // Restart the blink phase so a newly selected field is immediately visible.
            if (field_chg) begin
              blink_q     <= 1'b0;
              blink_cnt_q <= '0;
            end else if (blink_cnt_q == BlW'(BLINK_HALF - 1)) begin
              blink_q     <= ~blink_q;
              blink_cnt_q <= '0;
            end else begin
              blink_cnt_q <= blink_cnt_q + 1'b1;
            end
          end
        end
        StCommit: begin
          save_q   <= work_q;
          strobe_q <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign save_nowtime     = save_q;
  assign save_nowtime_yet = strobe_q;
  assign edit_field       = field_q;
  assign edit_active      = active_q;
  assign blink            = blink_q;

endmodule

// File: tb/tb_time_set_editor.sv
// Self-checking bench for time_set_editor: directed vector table, hand-written corner
// sequences and randomized edit sessions checked against an integer time model.
module tb_time_set_editor;

  localparam int unsigned DB = 2;
  localparam int unsigned BH = 4;
  localparam int BC = 0, BU = 1, BD = 2, BL = 3, BR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] nowtime;
  logic [4:0]  btn;
  logic [23:0] save_nowtime;
  logic        save_nowtime_yet;
  logic [1:0]  edit_field;
  logic        edit_active;
  logic        blink;

  int          total = 0;
  int          bad   = 0;
  logic [23:0] last_save = '0;

  always #5 clk = ~clk;

  time_set_editor #(.DB_CYCLES(DB), .BLINK_HALF(BH)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .nowtime         (nowtime),
    .btn_left        (btn[BL]),
    .btn_right       (btn[BR]),
    .btn_up          (btn[BU]),
    .btn_down        (btn[BD]),
    .btn_confirm     (btn[BC]),
    .save_nowtime    (save_nowtime),
    .save_nowtime_yet(save_nowtime_yet),
    .edit_field      (edit_field),
    .edit_active     (edit_active),
    .blink           (blink)
  );

  typedef struct {
    string       name;
    logic [23:0] load;
    logic [31:0] ops;   // op codes run from the least-significant nibble; 0 ends the list
    logic [1:0]  fld;
    logic [23:0] exp;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Integer model helpers: a field is kept as a plain number, BCD only at the edges.
  function automatic int bcd2int(input logic [7:0] b, input int lim);
    int v;
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return 0;
    v = int'(b[7:4]) * 10 + int'(b[3:0]);
    return (v < lim) ? v : 0;
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic press(input int b, input int hold);
    btn[b] = 1'b1;
    repeat (hold) @(negedge clk);
    btn[b] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic enter(input logic [23:0] t);
    nowtime = t;
    enable  = 1'b1;
    repeat (2) @(negedge clk);
    chk("enter_active", 32'(edit_active), 32'd1);
    chk("enter_field", 32'(edit_field), 32'd2);
    nowtime = 24'($urandom);  // captured value must not follow later changes
  endtask

  task automatic commit_check(input string name, input logic [23:0] exp, input bit keep_en);
    int nstb = 0;
    int pos  = -1;
    btn[BC] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (save_nowtime_yet) begin
        nstb++;
        pos = k;
      end
      if (k == 6) begin
        chk({name, "_save"}, 32'(save_nowtime), 32'(exp));
        btn[BC] = 1'b0;
        if (!keep_en) enable = 1'b0;
      end
      if (k == 7 && keep_en) chk({name, "_reenter"}, 32'(edit_active), 32'd1);
    end
    chk({name, "_strobes"}, 32'(nstb), 32'd1);
    chk({name, "_strobe_pos"}, 32'(pos), 32'd6);
    chk({name, "_held"}, 32'(save_nowtime), 32'(exp));
    last_save = exp;
  endtask

  initial begin
    logic [3:0]  op;
    logic [23:0] t;
    int          vals [3];
    int          lims [3];
    int          f;
    int          nstb;

    lims[0] = 60; lims[1] = 60; lims[2] = 24;
    tv[0]  = '{"passthru",   24'h123456, 32'h0,     2'd2, 24'h123456};
    tv[1]  = '{"hr_wrap",    24'h235959, 32'h1,     2'd2, 24'h005959};
    tv[2]  = '{"min_wrap",   24'h005959, 32'h14,    2'd1, 24'h000059};
    tv[3]  = '{"sec_wrap",   24'h000059, 32'h144,   2'd0, 24'h000000};
    tv[4]  = '{"dec_all",    24'h000000, 32'h24242, 2'd0, 24'h235959};
    tv[5]  = '{"left3",      24'h000000, 32'h333,   2'd2, 24'h000000};
    tv[6]  = '{"invalid",    24'h2A6F99, 32'h0,     2'd2, 24'h000000};
    tv[7]  = '{"hr09_up",    24'h095959, 32'h1,     2'd2, 24'h105959};
    tv[8]  = '{"hr19_up",    24'h195959, 32'h1,     2'd2, 24'h205959};
    tv[9]  = '{"hr20_dn",    24'h200000, 32'h2,     2'd2, 24'h190000};
    tv[10] = '{"min09_up",   24'h000909, 32'h14,    2'd1, 24'h001009};
    tv[11] = '{"sec10_dn",   24'h000010, 32'h244,   2'd0, 24'h000009};
    tv[12] = '{"mixed_bad",  24'h1F5960, 32'h0,     2'd2, 24'h005900};
    tv[13] = '{"hr23_ok",    24'h230000, 32'h0,     2'd2, 24'h230000};
    tv[14] = '{"right_wrap", 24'h000000, 32'h1444,  2'd2, 24'h010000};
    tv[15] = '{"left_up",    24'h000000, 32'h13,    2'd0, 24'h000001};

    rst = 1'b1; enable = 1'b0; nowtime = '0; btn = '0;
    repeat (2) @(negedge clk);
    chk("rst_save", 32'(save_nowtime), 32'd0);
    chk("rst_strobe", 32'(save_nowtime_yet), 32'd0);
    chk("rst_field", 32'(edit_field), 32'd2);
    chk("rst_active", 32'(edit_active), 32'd0);
    chk("rst_blink", 32'(blink), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      enter(tv[i].load);
      for (int n = 0; n < 8; n++) begin
        op = tv[i].ops[4*n +: 4];
        if (op == 4'd0) break;
        press(int'(op), 6);
      end
      chk({tv[i].name, "_field"}, 32'(edit_field), 32'(tv[i].fld));
      commit_check(tv[i].name, tv[i].exp, 1'b0);
    end

    // up and left in the same cycle: only up applies
    enter(24'h2A6F99);
    btn[BU] = 1'b1; btn[BL] = 1'b1;
    repeat (6) @(negedge clk);
    btn[BU] = 1'b0; btn[BL] = 1'b0;
    repeat (8) @(negedge clk);
    chk("up_left_field", 32'(edit_field), 32'd2);
    commit_check("up_left", 24'h010000, 1'b0);

    // one-cycle glitch ignored, long hold gives a single increment
    enter(24'h000000);
    btn[BU] = 1'b1;
    @(negedge clk);
    btn[BU] = 1'b0;
    repeat (10) @(negedge clk);
    press(BU, 10);
    commit_check("glitch_hold", 24'h010000, 1'b0);

    // blink phase from EDIT entry, then restart on a field change
    chk("blink_idle", 32'(blink), 32'd0);
    nowtime = 24'h000000;
    enable  = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("blink_run", 32'(blink), (k < 2) ? 32'd0 : 32'(((k - 2) / 4) % 2));
    end
    btn[BL] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 6) btn[BL] = 1'b0;
      if (k >= 5) chk("blink_restart", 32'(blink), (k <= 8) ? 32'd0 : 32'd1);
    end
    chk("blink_left_field", 32'(edit_field), 32'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("blink_off", 32'(blink), 32'd0);
    repeat (6) @(negedge clk);

    // abort: edits discarded, no strobe
    enter(24'h090000);
    press(BU, 6);
    enable = 1'b0;
    nstb = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (save_nowtime_yet) nstb++;
    end
    chk("abort_strobes", 32'(nstb), 32'd0);
    chk("abort_save", 32'(save_nowtime), 32'(last_save));
    chk("abort_active", 32'(edit_active), 32'd0);
    chk("abort_blink", 32'(blink), 32'd0);

    // abort in the same cycle as the confirm event wins
    enter(24'h120000);
    btn[BC] = 1'b1;
    nstb = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (save_nowtime_yet) nstb++;
      if (k == 4) enable = 1'b0;
      if (k == 6) btn[BC] = 1'b0;
    end
    chk("abort_conf_strobes", 32'(nstb), 32'd0);
    chk("abort_conf_save", 32'(save_nowtime), 32'(last_save));

    // randomized sessions against the integer model
    for (int trial = 0; trial < 10; trial++) begin
      if ($urandom_range(0, 1) == 1) t = 24'($urandom);
      else t = {int2bcd($urandom_range(0, 23)), int2bcd($urandom_range(0, 59)),
                int2bcd($urandom_range(0, 59))};
      vals[2] = bcd2int(t[23:16], 24);
      vals[1] = bcd2int(t[15:8], 60);
      vals[0] = bcd2int(t[7:0], 60);
      f = 2;
      enter(t);
      for (int n = 0, nops = $urandom_range(6, 12); n < nops; n++) begin
        op = 4'($urandom_range(1, 4));
        press(int'(op), 6);
        case (op)
          4'd1:    vals[f] = (vals[f] + 1) % lims[f];
          4'd2:    vals[f] = (vals[f] + lims[f] - 1) % lims[f];
          4'd3:    f = (f + 1) % 3;
          default: f = (f + 2) % 3;
        endcase
        chk("rand_field", 32'(edit_field), 32'(f));
      end
      commit_check("rand", {int2bcd(vals[2]), int2bcd(vals[1]), int2bcd(vals[0])}, 1'b0);
    end

    // commit with enable held re-enters, then reset mid-edit
    enter(24'h111111);
    commit_check("reenter", 24'h111111, 1'b1);
    press(BU, 6);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_save", 32'(save_nowtime), 32'd0);
    chk("midrst_strobe", 32'(save_nowtime_yet), 32'd0);
    chk("midrst_field", 32'(edit_field), 32'd2);
    chk("midrst_active", 32'(edit_active), 32'd0);
    chk("midrst_blink", 32'(blink), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_active", 32'(edit_active), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
